// File: rtl/rng_share_arbiter.sv
// Seeds and warms up a shared LFSR, then grants one fresh random word per request, round-robin.
// Optional grant statistics counter is built when RNG_ARB_STATS_EN is defined.
module rng_share_arbiter #(
  parameter int unsigned      N_REQ  = 4,
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] SEED   = WIDTH'(8'h1F),
  parameter int unsigned      WARMUP = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reseed,
  input  logic [WIDTH-1:0]  seed_in,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic              rvalid,
  output logic [WIDTH-1:0]  rdata,
  output logic              busy,
  output logic              gen_en,
  output logic              gen_load,
  output logic [WIDTH-1:0]  gen_seed,
  input  logic [WIDTH-1:0]  gen_data,
  output logic [15:0]       grant_count
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_WARM,
    ST_IDLE,
    ST_GNT
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              rvalid_q, rvalid_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic [WIDTH-1:0]  seed_q, seed_d;
  logic [7:0]        warm_cnt_q, warm_cnt_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [PTR_W-1:0]  win_idx;
  logic              win_found;
  int unsigned       cand;

  // Rotating priority search: first set request at or above the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = (32'(ptr_q) + i) % N_REQ;
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_SEED;
      gnt_q      <= '0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      seed_q     <= SEED;
      warm_cnt_q <= '0;
      ptr_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      seed_q     <= seed_d;
      warm_cnt_q <= warm_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (reseed) begin
      state_d = ST_SEED;
    end else begin
      unique case (state_q)
        ST_SEED: state_d = (WARMUP == 0) ? ST_IDLE : ST_WARM;
        ST_WARM: if (warm_cnt_q <= 8'd1) state_d = ST_IDLE;
        ST_IDLE: if (win_found) state_d = ST_GNT;
        ST_GNT:  state_d = ST_IDLE;
        default: state_d = ST_SEED;
      endcase
    end
  end

  // Grant pulses are rebuilt every cycle; only IDLE without reseed can raise them.
  always_comb begin
    gnt_d      = '0;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    seed_d     = seed_q;
    warm_cnt_d = warm_cnt_q;
    ptr_d      = ptr_q;
    if (reseed) begin
      seed_d = (seed_in == '0) ? SEED : seed_in;
    end else begin
      unique case (state_q)
        ST_SEED: warm_cnt_d = 8'(WARMUP);
        ST_WARM: warm_cnt_d = warm_cnt_q - 8'd1;
        ST_IDLE: begin
          if (win_found) begin
            gnt_d    = N_REQ'(1) << win_idx;
            rvalid_d = 1'b1;
            rdata_d  = gen_data;
            if (32'(win_idx) == N_REQ - 1) ptr_d = '0;
            else                            ptr_d = win_idx + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gen_load = (state_q == ST_SEED);
    gen_en   = (state_q == ST_WARM) || (state_q == ST_GNT);
    busy     = (state_q == ST_SEED) || (state_q == ST_WARM);
  end

  assign gnt      = gnt_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign gen_seed = seed_q;

`ifdef RNG_ARB_STATS_EN
  logic [15:0] grant_count_q, grant_count_d;
  logic        grant_now;

  always_comb begin
    grant_now     = (state_q == ST_IDLE) && win_found && !reseed;
    grant_count_d = grant_count_q;
    if (grant_now && (grant_count_q != 16'hFFFF)) grant_count_d = grant_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) grant_count_q <= '0;
    else     grant_count_q <= grant_count_d;
  end

  assign grant_count = grant_count_q;
`else
  assign grant_count = '0;
`endif

endmodule

// File: tb/tb_rng_share_arbiter.sv
// Randomized self-checking bench for rng_share_arbiter with a behavioural LFSR and grant model.
module tb_rng_share_arbiter;
  localparam int N  = 4;
  localparam int WU = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reseed = 1'b0;
  logic [7:0]  seed_in = '0;
  logic [3:0]  req = '0;
  logic [3:0]  gnt;
  logic        rvalid;
  logic [7:0]  rdata;
  logic        busy, gen_en, gen_load;
  logic [7:0]  gen_seed, gen_data, gen_q;
  logic [15:0] grant_count;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_word;
  int          exp_ptr;
  int          exp_count;

  rng_share_arbiter #(.N_REQ(4), .WIDTH(8), .SEED(8'h1F), .WARMUP(16)) dut (
    .clk(clk), .rst(rst), .reseed(reseed), .seed_in(seed_in), .req(req),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .gen_en(gen_en),
    .gen_load(gen_load), .gen_seed(gen_seed), .gen_data(gen_data),
    .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [7:0] warm(input logic [7:0] s);
    logic [7:0] v = s;
    repeat (WU) v = lfsr(v);
    return v;
  endfunction

  function automatic int win(input int p, input logic [3:0] r);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  function automatic logic [15:0] exp_gc();
`ifdef RNG_ARB_STATS_EN
    return (exp_count > 65535) ? 16'hFFFF : 16'(exp_count);
`else
    return 16'h0000;
`endif
  endfunction

  // Shared generator the arbiter drives
  always @(posedge clk) begin
    if (gen_load)    gen_q <= gen_seed;
    else if (gen_en) gen_q <= lfsr(gen_q);
  end
  assign gen_data = gen_q;

  task automatic test_reset;
    repeat (3) @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0 || rvalid !== 1'b0 || rdata !== 8'h00 || busy !== 1'b1 || grant_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_values: gnt=%b rvalid=%b rdata=%h busy=%b gc=%h, expected 0000 0 00 1 0000",
               gnt, rvalid, rdata, busy, grant_count);
    end
    rst = 1'b0;
    n_checks++;
    if (gen_load !== 1'b1 || gen_seed !== 8'h1F || gen_en !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL seed_cycle0: gen_load=%b gen_seed=%h gen_en=%b busy=%b, expected 1 1f 0 1",
               gen_load, gen_seed, gen_en, busy);
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      n_checks++;
      if (gen_load !== 1'b0 || gen_en !== (c <= WU) || busy !== (c <= WU) || gnt !== 4'b0) begin
        n_fail++;
        $display("FAIL warmup_cycle%0d: gen_load=%b gen_en=%b busy=%b gnt=%b, expected 0 %0b %0b 0000",
                 c, gen_load, gen_en, busy, gnt, c <= WU, c <= WU);
      end
    end
    exp_word = warm(8'h1F); exp_ptr = 0; exp_count = 0;
    n_checks++;
    if (gen_data !== exp_word) begin
      n_fail++;
      $display("FAIL warmup_steps: gen_data=%h, expected %h", gen_data, exp_word);
    end
  endtask

  task automatic test_round_robin;
    logic [3:0] tbl_req [8] = '{4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 4'b1001, 4'b1001};
    logic [3:0] tbl_gnt [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001, 4'b1000, 4'b0001};
    int w;
    for (int k = 0; k < 8; k++) begin
      req = tbl_req[k];
      @(negedge clk);
      w = win(exp_ptr, tbl_req[k]);
      n_checks++;
      if (gnt !== tbl_gnt[k] || gnt !== (4'b0001 << w) || rvalid !== 1'b1 || rdata !== exp_word) begin
        n_fail++;
        $display("FAIL rr_grant%0d: gnt=%b rvalid=%b rdata=%h, expected %b 1 %h",
                 k, gnt, rvalid, rdata, tbl_gnt[k], exp_word);
      end
      exp_word = lfsr(exp_word); exp_ptr = (w + 1) % N; exp_count++;
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0 || rvalid !== 1'b0) begin
        n_fail++;
        $display("FAIL rr_gap%0d: gnt=%b rvalid=%b, expected 0000 0", k, gnt, rvalid);
      end
    end
    req = '0;
  endtask

  task automatic test_single;
    logic [7:0] prev_gen;
    logic [7:0] seen [$];
    logic       dup;
    int         w;
    req = 4'b0100;
    for (int k = 0; k < 5; k++) begin
      prev_gen = gen_data;
      @(negedge clk);
      w = win(exp_ptr, req);
      n_checks++;
      if (gnt !== 4'b0100 || rvalid !== 1'b1 || gen_en !== 1'b1) begin
        n_fail++;
        $display("FAIL single_gnt%0d: gnt=%b rvalid=%b gen_en=%b, expected 0100 1 1", k, gnt, rvalid, gen_en);
      end
      n_checks++;
      if (rdata !== prev_gen || rdata !== exp_word) begin
        n_fail++;
        $display("FAIL single_rdata%0d: rdata=%h, expected %h (prev gen_data %h)", k, rdata, exp_word, prev_gen);
      end
      dup = 1'b0;
      foreach (seen[j]) if (seen[j] === rdata) dup = 1'b1;
      n_checks++;
      if (dup) begin
        n_fail++;
        $display("FAIL single_repeat%0d: rdata=%h already issued, expected a fresh word", k, rdata);
      end
      seen.push_back(rdata);
      exp_word = lfsr(exp_word); exp_ptr = (w + 1) % N; exp_count++;
      @(negedge clk);
      n_checks++;
      if (gnt !== 4'b0 || rvalid !== 1'b0 || rdata !== seen[$]) begin
        n_fail++;
        $display("FAIL single_hold%0d: gnt=%b rvalid=%b rdata=%h, expected 0000 0 %h", k, gnt, rvalid, rdata, seen[$]);
      end
    end
    req = '0;
  endtask

  task automatic test_random;
    logic [3:0] r;
    int         w;
    for (int k = 0; k < 40; k++) begin
      r   = 4'($urandom_range(0, 15));
      req = r;
      @(negedge clk);
      if (r == 4'b0) begin
        n_checks++;
        if (gnt !== 4'b0 || rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_nogrant%0d: gnt=%b rvalid=%b, expected 0000 0", k, gnt, rvalid);
        end
      end else begin
        w = win(exp_ptr, r);
        exp_count++;
        n_checks++;
        if (gnt !== (4'b0001 << w) || rvalid !== 1'b1 || rdata !== exp_word || grant_count !== exp_gc()) begin
          n_fail++;
          $display("FAIL rand_grant%0d: req=%b gnt=%b rvalid=%b rdata=%h gc=%h, expected %b 1 %h %h",
                   k, r, gnt, rvalid, rdata, grant_count, 4'b0001 << w, exp_word, exp_gc());
        end
        exp_word = lfsr(exp_word); exp_ptr = (w + 1) % N;
        req = 4'($urandom_range(0, 15));
        @(negedge clk);
        n_checks++;
        if (gnt !== 4'b0 || rvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL rand_gap%0d: gnt=%b rvalid=%b, expected 0000 0", k, gnt, rvalid);
        end
      end
    end
    req = '0;
  endtask

  task automatic test_reseed_gnt;
    int w;
    req = 4'b0001;
    @(negedge clk);
    w = win(exp_ptr, 4'b0001);
    n_checks++;
    if (gnt !== 4'b0001 || rvalid !== 1'b1 || rdata !== exp_word || gen_en !== 1'b1) begin
      n_fail++;
      $display("FAIL reseed_inflight: gnt=%b rvalid=%b rdata=%h gen_en=%b, expected 0001 1 %h 1",
               gnt, rvalid, rdata, gen_en, exp_word);
    end
    exp_ptr = (w + 1) % N; exp_count++;
    reseed = 1'b1; seed_in = 8'h00; req = 4'b1111;
    @(negedge clk);
    reseed = 1'b0;
    n_checks++;
    if (gnt !== 4'b0 || rvalid !== 1'b0 || gen_load !== 1'b1 || gen_seed !== 8'h1F || busy !== 1'b1 || gen_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reseed_seed: gnt=%b rvalid=%b gen_load=%b gen_seed=%h busy=%b gen_en=%b, expected 0000 0 1 1f 1 0",
               gnt, rvalid, gen_load, gen_seed, busy, gen_en);
    end
    for (int c = 1; c <= WU; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b1 || gnt !== 4'b0 || gen_en !== 1'b1 || gen_load !== 1'b0) begin
        n_fail++;
        $display("FAIL reseed_warm%0d: busy=%b gnt=%b gen_en=%b gen_load=%b, expected 1 0000 1 0",
                 c, busy, gnt, gen_en, gen_load);
      end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      n_fail++;
      $display("FAIL reseed_idle: busy=%b gnt=%b, expected 0 0000", busy, gnt);
    end
    exp_word = warm(8'h1F);
    @(negedge clk);
    w = win(exp_ptr, 4'b1111);
    exp_count++;
    n_checks++;
    if (gnt !== (4'b0001 << w) || rdata !== exp_word || grant_count !== exp_gc()) begin
      n_fail++;
      $display("FAIL reseed_first_grant: gnt=%b rdata=%h gc=%h, expected %b %h %h",
               gnt, rdata, grant_count, 4'b0001 << w, exp_word, exp_gc());
    end
    exp_word = lfsr(exp_word); exp_ptr = (w + 1) % N;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_reseed_value;
    logic [7:0] s;
    int         w;
    s = 8'($urandom_range(1, 255));
    reseed = 1'b1; seed_in = s; req = 4'b0010;
    @(negedge clk);
    reseed = 1'b0;
    n_checks++;
    if (gnt !== 4'b0 || gen_load !== 1'b1 || gen_seed !== s || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reseed_value: gnt=%b gen_load=%b gen_seed=%h busy=%b, expected 0000 1 %h 1",
               gnt, gen_load, gen_seed, busy, s);
    end
    repeat (WU + 1) @(negedge clk);
    exp_word = warm(s);
    @(negedge clk);
    w = win(exp_ptr, 4'b0010);
    exp_count++;
    n_checks++;
    if (gnt !== 4'b0010 || rdata !== exp_word) begin
      n_fail++;
      $display("FAIL reseed_value_grant: gnt=%b rdata=%h, expected 0010 %h", gnt, rdata, exp_word);
    end
    exp_word = lfsr(exp_word); exp_ptr = (w + 1) % N;
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_stats;
    int w;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (grant_count !== 16'h0) begin
      n_fail++;
      $display("FAIL stats_reset: grant_count=%h, expected 0000", grant_count);
    end
    rst = 1'b0;
    exp_word = warm(8'h1F); exp_ptr = 0; exp_count = 0;
    repeat (WU + 1) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      req = 4'b1110;
      @(negedge clk);
      w = win(exp_ptr, 4'b1110);
      n_checks++;
      if (gnt !== (4'b0001 << w) || rdata !== exp_word) begin
        n_fail++;
        $display("FAIL stats_grant%0d: gnt=%b rdata=%h, expected %b %h", k, gnt, rdata, 4'b0001 << w, exp_word);
      end
      exp_word = lfsr(exp_word); exp_ptr = (w + 1) % N; exp_count++;
      req = '0;
      @(negedge clk);
    end
    n_checks++;
    if (grant_count !== exp_gc()) begin
      n_fail++;
      $display("FAIL stats_count: grant_count=%h, expected %h", grant_count, exp_gc());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_random();
    test_reseed_gnt();
    test_reseed_value();
    test_stats();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
